design_switch_ctrl: RTL and testbench

- Parametrised, glitch-safe design-select controller for the multi-project user area.
- Replaces the combinational select/mux with a sequenced switchover:
  - synchronise and debounce `design_select`;
  - tristate pads and hold the old design in reset (drain);
  - hold the new design in reset for a fixed time, then route its GPIO.
- Sits between the top-level GPIO pins and the per-design wrappers, and drives each wrapper's chip select and reset.

---
 rtl/design_switch_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_design_switch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/design_switch_ctrl.sv
// design_switch_ctrl: sequenced design-select controller for the multi-project area.
// The select input is synchronised and debounced. A change of design then runs
// through a fixed sequence: drain (pads tristated, all designs held in reset),
// then reset of the incoming design, then routing of its GPIO to the pads.
// Optional build macro DESIGN_SWITCH_CNT_EN adds an 8-bit switch_count output.
// It counts completed switchovers and wraps at 255.
`timescale 1ns/1ps
module design_switch_ctrl #(
    parameter int NUM_DESIGNS   = 13,
    parameter int SEL_WIDTH     = 4,
    parameter int GPIO_WIDTH    = 34,
    parameter int STABLE_CYCLES = 4,
    parameter int RESET_CYCLES  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SEL_WIDTH-1:0]              design_select,
    input  logic [NUM_DESIGNS*GPIO_WIDTH-1:0] designs_gpio_out,
    input  logic [NUM_DESIGNS*GPIO_WIDTH-1:0] designs_gpio_oeb,
    output logic [GPIO_WIDTH-1:0]             gpio_out,
    output logic [GPIO_WIDTH-1:0]             gpio_oeb,
    output logic [NUM_DESIGNS-1:0]            designs_cs,
    output logic [NUM_DESIGNS-1:0]            designs_n_rst,
    output logic [SEL_WIDTH-1:0]              active_design,
    output logic                              switching
`ifdef DESIGN_SWITCH_CNT_EN
    ,
    output logic [7:0]                        switch_count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_RESET  = 2'd3;

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(RESET_CYCLES + 2);

    localparam logic [SEL_WIDTH-1:0] MAX_CODE   = SEL_WIDTH'(NUM_DESIGNS);
    localparam logic [CNT_W-1:0]     STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [TMR_W-1:0]     DRAIN_LAST = TMR_W'(1);
    localparam logic [TMR_W-1:0]     RESET_LAST = TMR_W'(RESET_CYCLES - 1);

    logic [SEL_WIDTH-1:0] sync1_reg;
    logic [SEL_WIDTH-1:0] sync2_reg;
    logic [SEL_WIDTH-1:0] norm1;
    logic [SEL_WIDTH-1:0] norm2;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_next;
    logic                 stable;

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [TMR_W-1:0]     timer_reg;
    logic [TMR_W-1:0]     timer_next;
    logic [SEL_WIDTH-1:0] target_reg;
    logic [SEL_WIDTH-1:0] target_next;
    logic [SEL_WIDTH-1:0] active_reg;
    logic [SEL_WIDTH-1:0] active_next;

    logic                 is_active;
    logic                 is_reset;

    logic [GPIO_WIDTH-1:0] slice_out [NUM_DESIGNS];
    logic [GPIO_WIDTH-1:0] slice_oeb [NUM_DESIGNS];

    // Codes of 0 or beyond the last design mean "no design".
    function automatic logic [SEL_WIDTH-1:0] normalise(input logic [SEL_WIDTH-1:0] code);
        return ((code != '0) && (code <= MAX_CODE)) ? code : '0;
    endfunction

    assign norm1 = normalise(sync1_reg);
    assign norm2 = normalise(sync2_reg);

    // Two-flop synchroniser for the asynchronous select input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= design_select;
            sync2_reg <= sync1_reg;
        end
    end

    // Stability counter. It clears on the edge where the normalised select takes a
    // new value, which shows up as the two synchroniser stages disagreeing. The
    // switchover decision uses the value the counter reaches on this same edge, so
    // a select that has been constant for STABLE_CYCLES edges is acted on at once.
    always_comb begin
        cnt_next = cnt_reg;
        if (norm1 != norm2) begin
            cnt_next = '0;
        end else if (cnt_reg != STABLE_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign stable = (cnt_next == STABLE_MAX);

    // Stability counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Switchover sequencer next-state logic. Requests arriving while a sequence
    // runs are ignored; the settled select is looked at again on return to
    // IDLE/ACTIVE, so the last request wins.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        target_next = target_reg;
        active_next = active_reg;
        case (state_reg)
            ST_IDLE, ST_ACTIVE: begin
                if (stable && (norm2 != active_reg)) begin
                    target_next = norm2;
                    timer_next  = '0;
                    state_next  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (timer_reg == DRAIN_LAST) begin
                    timer_next = '0;
                    if (target_reg == '0) begin
                        state_next  = ST_IDLE;
                        active_next = '0;
                    end else begin
                        state_next = ST_RESET;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                if (timer_reg == RESET_LAST) begin
                    timer_next  = '0;
                    state_next  = ST_ACTIVE;
                    active_next = target_reg;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            timer_reg  <= '0;
            target_reg <= '0;
            active_reg <= '0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            target_reg <= target_next;
            active_reg <= active_next;
        end
    end

    assign is_active     = (state_reg == ST_ACTIVE);
    assign is_reset      = (state_reg == ST_RESET);
    assign switching     = (state_reg == ST_DRAIN) || is_reset;
    assign active_design = active_reg;

    // Per-design unpacking plus chip-select / reset decode from registered state.
    generate
        for (genvar gi = 0; gi < NUM_DESIGNS; gi++) begin : g_design
            localparam logic [SEL_WIDTH-1:0] CODE = SEL_WIDTH'(gi + 1);
            assign slice_out[gi]     = designs_gpio_out[gi*GPIO_WIDTH +: GPIO_WIDTH];
            assign slice_oeb[gi]     = designs_gpio_oeb[gi*GPIO_WIDTH +: GPIO_WIDTH];
            assign designs_cs[gi]    = ~((is_active && (active_reg == CODE)) ||
                                         (is_reset  && (target_reg == CODE)));
            assign designs_n_rst[gi] = is_active && (active_reg == CODE);
        end
    endgenerate

    // Pad mux: combinational path from the active design to the pads; tristated otherwise.
    always_comb begin
        gpio_out = '0;
        gpio_oeb = '1;
        if (is_active) begin
            for (int k = 0; k < NUM_DESIGNS; k++) begin
                if (active_reg == SEL_WIDTH'(k + 1)) begin
                    gpio_out = slice_out[k];
                    gpio_oeb = slice_oeb[k];
                end
            end
        end
    end

`ifdef DESIGN_SWITCH_CNT_EN
    logic [7:0] switch_cnt_reg;

    // Count completed switchovers (RESET -> ACTIVE only); wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            switch_cnt_reg <= '0;
        end else if (is_reset && (state_next == ST_ACTIVE)) begin
            switch_cnt_reg <= switch_cnt_reg + 8'd1;
        end
    end

    assign switch_count = switch_cnt_reg;
`endif

endmodule

// File: tb/tb_design_switch_ctrl.sv
// tb_design_switch_ctrl: directed stimulus with a cycle-tagged scoreboard.
// Stimulus pushes hand-computed expectations tagged with the clock edge after
// which they must hold; a monitor on the falling edge pops and compares them.
`timescale 1ns/1ps
module tb_design_switch_ctrl;

    localparam int ND = 13;
    localparam int SW = 4;
    localparam int GW = 34;

    typedef struct {
        int          cyc;
        string       name;
        logic [SW-1:0] act;
        logic        sw;
        logic [ND-1:0] cs;
        logic [ND-1:0] nrst;
        logic [GW-1:0] gout;
        logic [GW-1:0] goeb;
        logic [7:0]  cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [SW-1:0]     design_select;
    logic [ND*GW-1:0]  designs_gpio_out;
    logic [ND*GW-1:0]  designs_gpio_oeb;
    logic [GW-1:0]     gpio_out;
    logic [GW-1:0]     gpio_oeb;
    logic [ND-1:0]     designs_cs;
    logic [ND-1:0]     designs_n_rst;
    logic [SW-1:0]     active_design;
    logic              switching;
    logic [7:0]        got_cnt;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] exp_sw;
    int         edge_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         base;
    int         prev_sel;
    bit         bad;

    always #5 clk = ~clk;

    design_switch_ctrl #(
        .NUM_DESIGNS(ND), .SEL_WIDTH(SW), .GPIO_WIDTH(GW),
        .STABLE_CYCLES(4), .RESET_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .design_select(design_select),
        .designs_gpio_out(designs_gpio_out),
        .designs_gpio_oeb(designs_gpio_oeb),
        .gpio_out(gpio_out),
        .gpio_oeb(gpio_oeb),
        .designs_cs(designs_cs),
        .designs_n_rst(designs_n_rst),
        .active_design(active_design),
        .switching(switching)
`ifdef DESIGN_SWITCH_CNT_EN
        ,
        .switch_count(got_cnt)
`endif
    );

`ifndef DESIGN_SWITCH_CNT_EN
    assign got_cnt = 8'd0;
`endif

    always @(posedge clk) edge_cnt++;

    function automatic logic [GW-1:0] pat_out(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {2'b10, b, 8'hA5, b, 8'h3C};
    endfunction

    function automatic logic [GW-1:0] pat_oeb(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {2'b01, 8'h5A, b, 8'hC3, b};
    endfunction

    function automatic logic [ND-1:0] cs_of(input int k);
        logic [ND-1:0] v;
        v = '1;
        if (k != 0) v[k-1] = 1'b0;
        return v;
    endfunction

    function automatic logic [ND-1:0] nrst_of(input int k);
        logic [ND-1:0] v;
        v = '0;
        v[k-1] = 1'b1;
        return v;
    endfunction

    task automatic push(input int cyc, input string nm, input int act, input bit sw,
                        input logic [ND-1:0] cs, input logic [ND-1:0] nrst,
                        input logic [GW-1:0] go, input logic [GW-1:0] goe);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.act = SW'(act); e.sw = sw;
        e.cs = cs; e.nrst = nrst; e.gout = go; e.goeb = goe; e.cnt = exp_sw;
        exp_q.push_back(e);
    endtask

    task automatic exp_idle(input int cyc, input string nm);
        push(cyc, nm, 0, 1'b0, '1, '0, '0, '1);
    endtask

    task automatic exp_active(input int cyc, input string nm, input int k);
        push(cyc, nm, k, 1'b0, cs_of(k), nrst_of(k), pat_out(k), pat_oeb(k));
    endtask

    task automatic exp_drain(input int cyc, input string nm, input int act);
        push(cyc, nm, act, 1'b1, '1, '0, '0, '1);
    endtask

    task automatic exp_reset(input int cyc, input string nm, input int act, input int tgt);
        push(cyc, nm, act, 1'b1, cs_of(tgt), '0, '0, '1);
    endtask

    // Full switchover from a settled state: old state through edge 5, drain on
    // edges 6-7, reset on edges 8-15, new design active from edge 16.
    task automatic do_switch(input int from, input int to, input string tag);
        @(negedge clk);
        design_select = SW'(to);
        base = edge_cnt;
        if (from == 0) exp_idle(base + 5, {tag, "_hold"});
        else           exp_active(base + 5, {tag, "_hold"}, from);
        exp_drain(base + 6, {tag, "_drain0"}, from);
        exp_drain(base + 7, {tag, "_drain1"}, from);
        exp_reset(base + 8, {tag, "_reset0"}, from, to);
        exp_reset(base + 15, {tag, "_reset7"}, from, to);
        exp_sw = exp_sw + 8'd1;
        exp_active(base + 16, {tag, "_active"}, to);
        repeat (17) @(negedge clk);
    endtask

    // Scoreboard monitor: compares every expectation due at this edge count.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            mon_e = exp_q.pop_front();
            checks++;
            bad = (active_design !== mon_e.act) || (switching !== mon_e.sw) ||
                  (designs_cs !== mon_e.cs) || (designs_n_rst !== mon_e.nrst) ||
                  (gpio_out !== mon_e.gout) || (gpio_oeb !== mon_e.goeb);
`ifdef DESIGN_SWITCH_CNT_EN
            bad = bad || (got_cnt !== mon_e.cnt);
`endif
            if (mon_e.cyc < edge_cnt) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d missed, now edge %0d", mon_e.name, mon_e.cyc, edge_cnt);
            end else if (bad) begin
                errors++;
                $display("FAIL %s edge=%0d: got act=%0d sw=%0b cs=%b nrst=%b out=%h oeb=%h cnt=%0d, expected act=%0d sw=%0b cs=%b nrst=%b out=%h oeb=%h cnt=%0d",
                         mon_e.name, edge_cnt, active_design, switching, designs_cs, designs_n_rst,
                         gpio_out, gpio_oeb, got_cnt, mon_e.act, mon_e.sw, mon_e.cs, mon_e.nrst,
                         mon_e.gout, mon_e.goeb, mon_e.cnt);
            end else begin
                $display("check %s edge=%0d ok: act=%0d sw=%0b cs=%b nrst=%b",
                         mon_e.name, edge_cnt, active_design, switching, designs_cs, designs_n_rst);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        design_select = '0;
        exp_sw = 8'd0;
        for (int k = 1; k <= ND; k++) begin
            designs_gpio_out[(k-1)*GW +: GW] = pat_out(k);
            designs_gpio_oeb[(k-1)*GW +: GW] = pat_oeb(k);
        end

        // Reset values while rst is held.
        @(negedge clk);
        exp_idle(edge_cnt + 1, "reset_idle0");
        exp_idle(edge_cnt + 2, "reset_idle1");
        repeat (3) @(negedge clk);

        // Select 3 from reset: drain after 6 edges, active after 16.
        rst = 1'b0;
        design_select = 4'd3;
        base = edge_cnt;
        exp_idle(base + 5, "t1_hold");
        exp_drain(base + 6, "t1_drain0", 0);
        exp_drain(base + 7, "t1_drain1", 0);
        exp_reset(base + 8, "t1_reset0", 0, 3);
        exp_reset(base + 15, "t1_reset7", 0, 3);
        exp_sw = exp_sw + 8'd1;
        push(base + 16, "t1_active3", 3, 1'b0, 13'b1111111111011, 13'b0000000000100,
             pat_out(3), pat_oeb(3));
        repeat (17) @(negedge clk);

        // 3 -> 7 and back to 3.
        do_switch(3, 7, "t2_3to7");
        do_switch(7, 3, "t2_7to3");

        // Two-cycle pulse to 5 is filtered; 3 stays active throughout.
        @(negedge clk);
        design_select = 4'd5;
        base = edge_cnt;
        exp_active(base + 4, "t3_pulse_a", 3);
        exp_active(base + 6, "t3_pulse_b", 3);
        exp_active(base + 10, "t3_pulse_c", 3);
        exp_active(base + 16, "t3_pulse_d", 3);
        repeat (2) @(negedge clk);
        design_select = 4'd3;
        repeat (16) @(negedge clk);

        // Out-of-range code 14: drain then idle, no reset phase.
        @(negedge clk);
        design_select = 4'd14;
        base = edge_cnt;
        exp_active(base + 5, "t4_hold", 3);
        exp_drain(base + 6, "t4_drain0", 3);
        exp_drain(base + 7, "t4_drain1", 3);
        exp_idle(base + 8, "t4_idle");
        exp_idle(base + 12, "t4_idle_late");
        repeat (14) @(negedge clk);

        // Select 3, then 9 during the reset of 3: 3 goes active for one cycle, then 9 takes over.
        @(negedge clk);
        design_select = 4'd3;
        base = edge_cnt;
        exp_idle(base + 5, "t5_hold");
        exp_drain(base + 6, "t5_drain0", 0);
        exp_reset(base + 8, "t5_reset0", 0, 3);
        exp_reset(base + 15, "t5_reset7", 0, 3);
        exp_sw = exp_sw + 8'd1;
        exp_active(base + 16, "t5_active3", 3);
        exp_drain(base + 17, "t5_drain9_0", 3);
        exp_drain(base + 18, "t5_drain9_1", 3);
        exp_reset(base + 19, "t5_reset9_0", 3, 9);
        exp_reset(base + 26, "t5_reset9_7", 3, 9);
        exp_sw = exp_sw + 8'd1;
        exp_active(base + 27, "t5_active9", 9);
        repeat (10) @(negedge clk);
        design_select = 4'd9;
        repeat (19) @(negedge clk);

        // Asynchronous reset in the middle of the reset phase of design 2.
        @(negedge clk);
        design_select = 4'd2;
        base = edge_cnt;
        exp_active(base + 5, "t6_hold", 9);
        exp_drain(base + 6, "t6_drain0", 9);
        exp_reset(base + 8, "t6_reset0", 9, 2);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        design_select = '0;
        exp_sw = 8'd0;
        exp_idle(edge_cnt, "t6_async_rst");
        exp_idle(edge_cnt + 1, "t6_rst_hold");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = edge_cnt;
        exp_idle(base + 8, "t6_post_rst");
        repeat (10) @(negedge clk);

`ifdef DESIGN_SWITCH_CNT_EN
        // 256 switchovers: the counter wraps back to 0 on the last one.
        prev_sel = 0;
        for (int i = 0; i < 256; i++) begin
            do_switch(prev_sel, (i % 2 == 0) ? 1 : 2, "wrap");
            prev_sel = (i % 2 == 0) ? 1 : 2;
        end
`else
        prev_sel = 0;
        do_switch(prev_sel, 13, "t7_last_design");
`endif

        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d never checked", mon_e.name, mon_e.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
